// File: rtl/add_round_key_pipe.sv
`timescale 1ns/1ps
// add_round_key_pipe: AES AddRoundKey stage with an internal round-key bank and an
// elastic valid/ready pipeline of STAGES register stages.
// Optional feature macro: ARK_PARITY_EN adds per-byte even parity that travels with the data;
// when undefined, out_parity is tied to 0 and no parity logic is built.
module add_round_key_pipe #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned NUM_KEYS = 11,
    parameter int unsigned STAGES   = 2,
    localparam int unsigned KEY_AW  = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_wr_en,
    input  logic [KEY_AW-1:0]   key_wr_idx,
    input  logic [DATA_W-1:0]   key_wr_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [KEY_AW-1:0]   in_round,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [KEY_AW-1:0]   out_round,
    output logic [DATA_W/8-1:0] out_parity,
    output logic                err_round,
    output logic [15:0]         beat_cnt
);

    localparam int unsigned PAR_W = DATA_W / 8;
    // Index bound widened by one bit so idx >= NUM_KEYS compares cleanly for any NUM_KEYS.
    localparam logic [KEY_AW:0] NUM_KEYS_L = (KEY_AW + 1)'(NUM_KEYS);

    logic [DATA_W-1:0] bank_q [NUM_KEYS];

    logic              advance;
    logic              accept;
    logic              wr_ok;
    logic              round_ok;
    logic [DATA_W-1:0] key_sel;
    logic [DATA_W-1:0] xor_res;

    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q  [STAGES];
    logic [KEY_AW-1:0] round_q [STAGES];

    logic              err_q;
    logic [15:0]       cnt_q;

    // One global stall: every stage moves only when the output slot is free or draining.
    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign wr_ok    = key_wr_en && ({1'b0, key_wr_idx} < NUM_KEYS_L);
    assign round_ok = {1'b0, in_round} < NUM_KEYS_L;

    // Key select; an out-of-range round uses an all-zero key so data passes through.
    always_comb begin
        key_sel = '0;
        if (round_ok) begin
            key_sel = bank_q[in_round];
        end
    end

    assign xor_res = in_data ^ key_sel;

    // Round-key bank; the read above sees the old entry during a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_ok) begin
            bank_q[key_wr_idx] <= key_wr_data;
        end
    end

    // Pipeline stages: stage 0 captures the XOR result, later stages only shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                round_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= accept;
            if (accept) begin
                data_q[0]  <= xor_res;
                round_q[0] <= in_round;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i]  <= data_q[i-1];
                    round_q[i] <= round_q[i-1];
                end
            end
        end
    end

    // Sticky bad-round flag and wrapping output handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (accept && !round_ok) begin
                err_q <= 1'b1;
            end
            if (valid_q[STAGES-1] && out_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

`ifdef ARK_PARITY_EN
    logic [PAR_W-1:0] par_in;
    logic [PAR_W-1:0] par_q [STAGES];

    // Per-byte even parity of the stage-0 result.
    always_comb begin
        par_in = '0;
        for (int i = 0; i < PAR_W; i++) begin
            par_in[i] = ^xor_res[8*i +: 8];
        end
    end

    // Parity shifts in lockstep with the data so it shares latency and stall behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                par_q[i] <= '0;
            end
        end else if (advance) begin
            if (accept) begin
                par_q[0] <= par_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (valid_q[i-1]) begin
                    par_q[i] <= par_q[i-1];
                end
            end
        end
    end

    assign out_parity = par_q[STAGES-1];
`else
    assign out_parity = '0;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_round = round_q[STAGES-1];
    assign err_round = err_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for add_round_key_pipe: scoreboard queues filled on accept,
// drained and compared on output handshakes.
module tb_add_round_key_pipe;

    localparam int DATA_W   = 128;
    localparam int NUM_KEYS = 11;
    localparam int STAGES   = 2;
    localparam int KEY_AW   = 4;
    localparam int PAR_W    = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_wr_en = 1'b0;
    logic [KEY_AW-1:0] key_wr_idx = '0;
    logic [DATA_W-1:0] key_wr_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEY_AW-1:0] in_round = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [KEY_AW-1:0] out_round;
    logic [PAR_W-1:0]  out_parity;
    logic              err_round;
    logic [15:0]       beat_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    logic [DATA_W-1:0] mbank [NUM_KEYS];
    logic [DATA_W-1:0] exp_d [$];
    logic [KEY_AW-1:0] exp_r [$];

    always #5 clk = ~clk;

    add_round_key_pipe #(
        .DATA_W  (DATA_W),
        .NUM_KEYS(NUM_KEYS),
        .STAGES  (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_wr_en  (key_wr_en),
        .key_wr_idx (key_wr_idx),
        .key_wr_data(key_wr_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_round   (in_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_round  (out_round),
        .out_parity (out_parity),
        .err_round  (err_round),
        .beat_cnt   (beat_cnt)
    );

    function automatic logic [PAR_W-1:0] exp_par(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
`ifdef ARK_PARITY_EN
        for (int i = 0; i < PAR_W; i++) p[i] = ^d[8*i +: 8];
`endif
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] model_xor(input logic [DATA_W-1:0] d,
                                                    input logic [KEY_AW-1:0] r);
        if (int'(r) < NUM_KEYS) return d ^ mbank[r];
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_KEYS; i++) mbank[i] = '0;
        exp_d.delete();
        exp_r.delete();
        exp_cnt = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        key_wr_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    task automatic write_key(input logic [KEY_AW-1:0] idx, input logic [DATA_W-1:0] k);
        key_wr_en = 1'b1;
        key_wr_idx = idx;
        key_wr_data = k;
        @(posedge clk);
        #1 key_wr_en = 1'b0;
        if (int'(idx) < NUM_KEYS) mbank[idx] = k;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_data !== '0 || out_round !== '0 || out_parity !== '0) begin
            errors++; $display("FAIL reset_out_data got %h/%0d/%h want 0", out_data, out_round,
                               out_parity);
        end
        checks++;
        if (err_round !== 1'b0 || beat_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_status got err=%b cnt=%0d want 0/0", err_round,
                               beat_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fips_round0();
        logic [DATA_W-1:0] want;
        int lat;
        want = 128'h00102030405060708090a0b0c0d0e0f0;
        write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        in_valid = 1'b1;
        in_data = 128'h00112233445566778899aabbccddeeff;
        in_round = 4'd0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL fips_accept got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            lat++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != STAGES) begin
            errors++; $display("FAIL fips_latency got %0d want %0d", lat, STAGES);
        end
        checks++;
        if (out_data !== want || out_round !== 4'd0 || out_parity !== exp_par(want)) begin
            errors++; $display("FAIL fips_data got %h/%0d/%h want %h/0/%h", out_data, out_round,
                               out_parity, want, exp_par(want));
        end
        if (out_valid && out_ready) exp_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || beat_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL fips_after got valid=%b cnt=%0d want 0/%0d", out_valid,
                               beat_cnt, exp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int sent, recv, cyc;
        logic stalled_prev;
        logic [DATA_W-1:0] held_d, ed;
        logic [KEY_AW-1:0] held_r, er;
        logic [PAR_W-1:0] held_p;
        apply_reset();
        for (int k = 0; k < NUM_KEYS; k++) write_key(4'(k), rnd128());
        sent = 0; recv = 0; cyc = 0; stalled_prev = 1'b0;
        held_d = '0; held_r = '0; held_p = '0;
        in_valid = 1'b1;
        in_data = rnd128();
        in_round = 4'd0;
        while (recv < 8 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            if (stalled_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_round !== held_r ||
                    out_parity !== held_p) begin
                    errors++; $display("FAIL bp_stall_hold got %b/%h/%0d want 1/%h/%0d",
                                       out_valid, out_data, out_round, held_d, held_r);
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_d = out_data; held_r = out_round; held_p = out_parity;
            if (out_valid && out_ready) begin
                recv++; exp_cnt++;
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL bp_beat got extra beat %h want none", out_data);
                end else begin
                    ed = exp_d.pop_front(); er = exp_r.pop_front();
                    if (out_data !== ed || out_round !== er || out_parity !== exp_par(ed)) begin
                        errors++; $display("FAIL bp_beat got %h/%0d/%h want %h/%0d/%h", out_data,
                                           out_round, out_parity, ed, er, exp_par(ed));
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(model_xor(in_data, in_round));
                exp_r.push_back(in_round);
                sent++;
            end
            @(posedge clk);
            #1;
            if (sent < 8) begin
                in_data = rnd128();
                in_round = 4'(sent % NUM_KEYS);
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (recv != 8 || exp_d.size() != 0) begin
            errors++; $display("FAIL bp_count got recv=%0d left=%0d want 8/0", recv,
                               exp_d.size());
        end
        @(negedge clk);
        checks++;
        if (beat_cnt !== 16'd8) begin
            errors++; $display("FAIL bp_beat_cnt got %0d want 8", beat_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_same_cycle_key();
        logic [DATA_W-1:0] ka, kb, d1, d2, ed;
        int cyc;
        ka = rnd128(); kb = rnd128(); d1 = rnd128(); d2 = rnd128();
        exp_d.delete(); exp_r.delete();
        write_key(4'd3, ka);
        out_ready = 1'b1;
        key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = kb;
        in_valid = 1'b1; in_data = d1; in_round = 4'd3;
        @(negedge clk);
        if (in_ready) begin exp_d.push_back(d1 ^ ka); exp_r.push_back(4'd3); end
        @(posedge clk);
        #1 key_wr_en = 1'b0; mbank[3] = kb;
        in_data = d2;
        @(negedge clk);
        if (in_ready) begin exp_d.push_back(d2 ^ kb); exp_r.push_back(4'd3); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (exp_d.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ed = exp_d.pop_front(); void'(exp_r.pop_front()); exp_cnt++;
                checks++;
                if (out_data !== ed || out_round !== 4'd3 || out_parity !== exp_par(ed)) begin
                    errors++; $display("FAIL same_key_beat got %h/%0d want %h/3", out_data,
                                       out_round, ed);
                end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (exp_d.size() != 0) begin
            errors++; $display("FAIL same_key_drain got %0d left want 0", exp_d.size());
        end
    endtask

    task automatic test_bad_round();
        logic [DATA_W-1:0] dbad, dgood, ed;
        int cyc;
        dbad = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        dgood = rnd128();
        exp_d.delete(); exp_r.delete();
        @(negedge clk);
        checks++;
        if (err_round !== 1'b0) begin
            errors++; $display("FAIL bad_round_pre got %b want 0", err_round);
        end
        @(posedge clk);
        #1 in_valid = 1'b1; in_data = dbad; in_round = 4'(NUM_KEYS); out_ready = 1'b1;
        @(negedge clk);
        if (in_ready) begin exp_d.push_back(dbad); exp_r.push_back(4'(NUM_KEYS)); end
        @(posedge clk);
        #1 in_data = dgood; in_round = 4'd1;
        @(negedge clk);
        if (in_ready) begin exp_d.push_back(dgood ^ mbank[1]); exp_r.push_back(4'd1); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (exp_d.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ed = exp_d.pop_front(); exp_cnt++;
                checks++;
                if (out_data !== ed || out_round !== exp_r.pop_front()) begin
                    errors++; $display("FAIL bad_round_beat got %h/%0d want %h", out_data,
                                       out_round, ed);
                end
            end
            @(posedge clk); #1; cyc++;
        end
        @(negedge clk);
        checks++;
        if (err_round !== 1'b1 || exp_d.size() != 0) begin
            errors++; $display("FAIL bad_round_sticky got err=%b left=%0d want 1/0", err_round,
                               exp_d.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        logic stale;
        int cyc;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = rnd128(); in_round = 4'd2;
        @(posedge clk);
        #1 in_data = rnd128();
        @(posedge clk);
        #1 in_valid = 1'b0; rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || err_round !== 1'b0 || beat_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_clear got v=%b err=%b cnt=%0d want 0/0/0",
                               out_valid, err_round, beat_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_stale got stale=%b ready=%b want 0/1", stale,
                               in_ready);
        end
        @(posedge clk);
        // Bank must read back zero, so the data passes through unchanged.
        d = rnd128();
        #1 in_valid = 1'b1; in_data = d; in_round = 4'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (out_valid !== 1'b1 && cyc < 20);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_round !== 4'd5) begin
            errors++; $display("FAIL rst_mid_bank got %b/%h want 1/%h", out_valid, out_data, d);
        end
        if (out_valid && out_ready) exp_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_parity_and_wrap();
        logic [DATA_W-1:0] d;
        logic want_bit;
        int acc, cyc;
`ifdef ARK_PARITY_EN
        want_bit = 1'b1;
`else
        want_bit = 1'b0;
`endif
        d = 128'h0123456789abcdef0011223344550307;
        in_valid = 1'b1; in_data = d; in_round = 4'd0; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (out_valid !== 1'b1 && cyc < 20);
        checks++;
        if (out_data !== d || out_parity[0] !== want_bit || out_parity[1] !== 1'b0 ||
            out_parity !== exp_par(d)) begin
            errors++; $display("FAIL parity got %h/%h want %h/%h", out_data, out_parity, d,
                               exp_par(d));
        end
        if (out_valid && out_ready) exp_cnt++;
        @(posedge clk);
        #1 in_valid = 1'b1; in_data = rnd128(); in_round = 4'd0;
        acc = exp_cnt; cyc = 0;
        while (exp_cnt < 65536 && cyc < 70000) begin
            @(negedge clk);
            if (out_valid && out_ready) exp_cnt++;
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc >= 65536) in_valid = 1'b0;
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (exp_cnt != 65536 || beat_cnt !== 16'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL wrap got cnt=%0d hs=%0d valid=%b want 0/65536/0", beat_cnt,
                               exp_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fips_round0();
        test_backpressure();
        test_same_cycle_key();
        test_bad_round();
        test_reset_mid();
        test_parity_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
